// File: rtl/id_stage_stall_controller.sv
// Decode-stage freeze/bubble/flush sequencer with RUN/STALL/HALT states.
// Optional saturating stall/flush performance counters are built when STALL_PERF_EN is defined.
module id_stage_stall_controller #(
  parameter int MAX_STALL = 2,
  parameter int CNT_W     = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall_Req,
  input  logic [1:0]  Stall_Len,
  input  logic        Branch_Taken,
  input  logic        Halt_Req,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        Busy,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] ONE_N = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_eff;

  // Effective stall length: zero means one cycle, oversize requests clamp to MAX_STALL.
  always_comb begin
    if (Stall_Len == 2'd0) begin
      n_eff = ONE_N;
    end else if ({30'd0, Stall_Len} > 32'(MAX_STALL)) begin
      n_eff = MAX_N;
    end else begin
      n_eff = CNT_W'(Stall_Len);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Busy         = 1'b0;

    if (Reset) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      state_d      = ST_RUN;
      cnt_d        = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (Halt_Req) begin
            // The halt instruction itself still moves into EX.
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            state_d     = ST_HALT;
          end else if (Stall_Req) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            if (n_eff != ONE_N) begin
              cnt_d   = n_eff - ONE_N;
              state_d = ST_STALL;
            end
          end else if (Branch_Taken) begin
            IF_ID_Flush = 1'b1;
          end
        end
        ST_STALL: begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          Busy         = 1'b1;
          cnt_d        = cnt_q - ONE_N;
          if (cnt_q <= ONE_N) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_HALT: begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_inc, flush_inc;

  assign stall_inc = !Reset && !PC_Write && (state_q != ST_HALT);
  assign flush_inc = !Reset && IF_ID_Flush && (state_q == ST_RUN);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_inc && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;
`else
  assign Stall_Count = 32'd0;
  assign Flush_Count = 32'd0;
`endif

endmodule

// File: tb/tb_id_stage_stall_controller.sv
// Self-checking bench for id_stage_stall_controller: directed scenarios plus randomized run vs. reference model.
module tb_id_stage_stall_controller;

  logic        clk = 1'b0;
  logic        Reset, Stall_Req, Branch_Taken, Halt_Req;
  logic [1:0]  Stall_Len;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Busy;
  logic [31:0] Stall_Count, Flush_Count;
  logic [4:0]  outs;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] O_RST   = 5'b00110;
  localparam logic [4:0] O_IDLE  = 5'b11000;
  localparam logic [4:0] O_DET   = 5'b00010;
  localparam logic [4:0] O_STALL = 5'b00011;
  localparam logic [4:0] O_HENT  = 5'b00000;
  localparam logic [4:0] O_HALT  = 5'b00110;
  localparam logic [4:0] O_BR    = 5'b11100;

  id_stage_stall_controller #(.MAX_STALL(2), .CNT_W(2)) dut (
    .Clock(clk), .Reset(Reset), .Stall_Req(Stall_Req), .Stall_Len(Stall_Len),
    .Branch_Taken(Branch_Taken), .Halt_Req(Halt_Req),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .Busy(Busy),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  always #5 clk = ~clk;
  assign outs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Busy};

  // Drive one cycle's inputs, then settle at the falling edge for sampling.
  task automatic drive(input bit r, input bit h, input bit s, input logic [1:0] l, input bit b);
    Reset = r; Halt_Req = h; Stall_Req = s; Stall_Len = l; Branch_Taken = b;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 2'd0, 0);
      n_checks++;
      if (outs !== O_RST) begin n_fail++; $display("FAIL reset_c%0d outs=%b expected=%b", i, outs, O_RST); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 2'd0, 0);
      n_checks++;
      if (outs !== O_IDLE) begin n_fail++; $display("FAIL idle_c%0d outs=%b expected=%b", i, outs, O_IDLE); end
      tick();
    end
    n_checks++;
    if (Stall_Count !== 32'd0 || Flush_Count !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters stall=%0d flush=%0d expected=0/0", Stall_Count, Flush_Count);
    end
  endtask

  // Issues a one-cycle stall request of length len and checks the following cycles against exp.
  task automatic run_stall(input string name, input logic [1:0] len, input int ncyc, input logic [4:0] exp [4]);
    for (int i = 0; i < ncyc; i++) begin
      drive(0, 0, (i == 0), len, 0);
      n_checks++;
      if (outs !== exp[i]) begin n_fail++; $display("FAIL %s_c%0d outs=%b expected=%b", name, i, outs, exp[i]); end
      tick();
    end
  endtask

  task automatic test_stall_len2();
    logic [4:0] e [4];
    e = '{O_DET, O_STALL, O_IDLE, O_IDLE};
    run_stall("stall_len2", 2'd2, 4, e);
  endtask

  task automatic test_clamp();
    logic [4:0] e3 [4];
    logic [4:0] e0 [4];
    e3 = '{O_DET, O_STALL, O_IDLE, O_IDLE};
    e0 = '{O_DET, O_IDLE, O_IDLE, O_IDLE};
    run_stall("stall_len3", 2'd3, 3, e3);
    run_stall("stall_len0", 2'd0, 2, e0);
  endtask

  task automatic test_stall_branch();
    drive(0, 0, 1, 2'd1, 1);
    n_checks++;
    if (outs !== O_DET) begin n_fail++; $display("FAIL stall_br_c0 outs=%b expected=%b", outs, O_DET); end
    tick();
    drive(0, 0, 0, 2'd1, 1);
    n_checks++;
    if (outs !== O_BR) begin n_fail++; $display("FAIL stall_br_c1 outs=%b expected=%b", outs, O_BR); end
    tick();
    drive(0, 0, 0, 2'd0, 0);
    n_checks++;
    if (outs !== O_IDLE) begin n_fail++; $display("FAIL stall_br_c2 outs=%b expected=%b", outs, O_IDLE); end
    tick();
  endtask

  task automatic test_halt();
    drive(0, 1, 1, 2'd2, 1);
    n_checks++;
    if (outs !== O_HENT) begin n_fail++; $display("FAIL halt_entry outs=%b expected=%b", outs, O_HENT); end
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      n_checks++;
      if (outs !== O_HALT) begin n_fail++; $display("FAIL halt_hold_c%0d outs=%b expected=%b", i, outs, O_HALT); end
      tick();
    end
    drive(1, 0, 0, 2'd0, 0);
    n_checks++;
    if (outs !== O_RST) begin n_fail++; $display("FAIL halt_reset outs=%b expected=%b", outs, O_RST); end
    tick();
    drive(0, 0, 0, 2'd0, 0);
    n_checks++;
    if (outs !== O_IDLE) begin n_fail++; $display("FAIL halt_exit outs=%b expected=%b", outs, O_IDLE); end
    tick();
  endtask

  // Reset mid-stall: forced outputs that cycle, RUN the next.
  task automatic test_reset_mid_stall();
    drive(0, 0, 1, 2'd2, 0);
    tick();
    drive(1, 0, 0, 2'd0, 0);
    n_checks++;
    if (outs !== O_RST) begin n_fail++; $display("FAIL midstall_reset outs=%b expected=%b", outs, O_RST); end
    tick();
    drive(0, 0, 0, 2'd0, 0);
    n_checks++;
    if (outs !== O_IDLE) begin n_fail++; $display("FAIL midstall_after outs=%b expected=%b", outs, O_IDLE); end
    tick();
  endtask

  task automatic test_perf();
    logic [31:0] exp_s, exp_f;
    drive(1, 0, 0, 2'd0, 0); tick();
    drive(0, 0, 1, 2'd2, 0); tick();
    drive(0, 0, 0, 2'd0, 0); tick();
    drive(0, 0, 0, 2'd0, 1); tick();
    drive(0, 0, 1, 2'd2, 1); tick();
    drive(0, 0, 0, 2'd0, 1); tick();
    drive(0, 0, 0, 2'd0, 1); tick();
    drive(0, 0, 0, 2'd0, 1); tick();
    drive(0, 0, 0, 2'd0, 0);
`ifdef STALL_PERF_EN
    exp_s = 32'd4; exp_f = 32'd3;
`else
    exp_s = 32'd0; exp_f = 32'd0;
`endif
    n_checks++;
    if (Stall_Count !== exp_s) begin n_fail++; $display("FAIL perf_stall got=%0d expected=%0d", Stall_Count, exp_s); end
    n_checks++;
    if (Flush_Count !== exp_f) begin n_fail++; $display("FAIL perf_flush got=%0d expected=%0d", Flush_Count, exp_f); end
    tick();
  endtask

  // Reference model: a count of remaining frozen cycles plus a halted flag.
  task automatic test_random();
    int          m_rem = 0;
    bit          m_halt = 0;
    longint      m_sc = 0, m_fc = 0;
    logic [4:0]  exp;
    logic [31:0] exp_sc, exp_fc;
    bit r, h, s, b;
    logic [1:0] l;
    int n;
    for (int i = 0; i < 400; i++) begin
      r = (i == 0) || ($urandom_range(0, 39) == 0);
      h = ($urandom_range(0, 29) == 0);
      s = ($urandom_range(0, 3) == 0);
      l = 2'($urandom_range(0, 3));
      b = ($urandom_range(0, 2) == 0);
      drive(r, h, s, l, b);
      if (r)          exp = O_RST;
      else if (m_halt) exp = O_HALT;
      else if (m_rem > 0) exp = O_STALL;
      else if (h)     exp = O_HENT;
      else if (s)     exp = O_DET;
      else if (b)     exp = O_BR;
      else            exp = O_IDLE;
      n_checks++;
      if (outs !== exp) begin n_fail++; $display("FAIL rand_outs_c%0d outs=%b expected=%b", i, outs, exp); end
`ifdef STALL_PERF_EN
      exp_sc = 32'(m_sc); exp_fc = 32'(m_fc);
`else
      exp_sc = 32'd0; exp_fc = 32'd0;
`endif
      if (i > 0) begin
        n_checks++;
        if (Stall_Count !== exp_sc || Flush_Count !== exp_fc) begin
          n_fail++;
          $display("FAIL rand_counters_c%0d stall=%0d flush=%0d expected=%0d/%0d", i, Stall_Count, Flush_Count, exp_sc, exp_fc);
        end
      end
      if (r) begin
        m_rem = 0; m_halt = 0; m_sc = 0; m_fc = 0;
      end else begin
        if (!m_halt && !exp[4]) m_sc++;
        if (!m_halt && m_rem == 0 && exp[2]) m_fc++;
        if (m_halt) begin
        end else if (m_rem > 0) begin
          m_rem--;
        end else if (h) begin
          m_halt = 1;
        end else if (s) begin
          n = (l == 0) ? 1 : ((int'(l) > 2) ? 2 : int'(l));
          m_rem = n - 1;
        end
      end
      tick();
    end
  endtask

  initial begin
    Reset = 1; Stall_Req = 0; Stall_Len = 0; Branch_Taken = 0; Halt_Req = 0;
    tick();
    test_reset();
    test_stall_len2();
    test_clamp();
    test_stall_branch();
    test_halt();
    test_reset_mid_stall();
    test_perf();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_stall_controller.md
Name: id_stage_stall_controller

Overview:
- Sequences the freeze, bubble and flush controls around the decode stage.
- Consumes the hazard-detection stall request, its required stall length, and the branch-resolved PCSel from decode.
- Drives the PC write enable, IF/ID write enable, IF/ID flush and ID/EX bubble so multi-cycle load-use and branch-operand stalls complete without losing or duplicating instructions.
- Also owns a terminal HALT state for end-of-program.

Parameters:
- MAX_STALL, 2, largest stall length in cycles accepted from Stall_Len; larger requests are clamped to this.
- CNT_W, 2, width of the internal stall down-counter; must hold MAX_STALL.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Stall_Req  input  1  hazard detected in ID this cycle.
- Stall_Len  input  2  total stall cycles required (0 treated as 1).
- Branch_Taken  input  1  PCSel from ID: branch/jump resolved taken this cycle.
- Halt_Req  input  1  decoded halt instruction in ID.
- PC_Write  output  1  PC register load enable.
- IF_ID_Write  output  1  IF/ID register load enable.
- IF_ID_Flush  output  1  clear IF/ID to NOP on the next edge.
- ID_EX_Bubble  output  1  load NOP control word into ID/EX on the next edge.
- Busy  output  1  multi-cycle stall in progress (state STALL).
- Stall_Count  output  32  stall-cycle counter (optional feature).
- Flush_Count  output  32  flush counter (optional feature).

Behaviour:
- States: RUN, STALL, HALT. Registered state and counter cnt. Outputs are a Mealy decode of state and inputs, so a hazard freezes the pipe in the cycle it is detected.
- Reset (synchronous, sampled on Clock): next state RUN, cnt=0, perf counters=0.
- While Reset=1, outputs are forced to PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, Busy=0.
- Effective length: N = max(1, min(Stall_Len, MAX_STALL)).
- RUN, idle outputs: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, Busy=0.
- RUN, input priority: Halt_Req > Stall_Req > Branch_Taken.
- RUN, Halt_Req=1: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=0 so the halt instruction itself proceeds. Next state HALT.
- RUN, Stall_Req=1: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. Branch_Taken is ignored this cycle because operands are not ready. If N==1, stay RUN; else cnt<=N-1 and go to STALL.
- RUN, Branch_Taken=1 (no stall, no halt): PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1. One-cycle penalty, no state change.
- STALL: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, Busy=1. Stall_Req, Branch_Taken and Halt_Req are ignored. cnt decrements each cycle; when cnt==1, next state RUN.
- On the RUN re-entry cycle, inputs are re-evaluated normally. A persisting Stall_Req starts a new stall; a now-valid branch flushes.
- HALT: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, Busy=0. Exit only via Reset.
- Reset asserted mid-STALL or in HALT: the forced reset outputs apply that cycle; the next cycle is RUN.
- Total frozen cycles per stall event is exactly N, including the detection cycle.

Optional Feature:
- Macro: STALL_PERF_EN.
- Defined: Stall_Count increments every cycle with PC_Write=0 outside HALT and outside reset. Flush_Count increments every cycle IF_ID_Flush=1 in RUN. Both saturate at 32'hFFFFFFFF and clear on Reset.
- Undefined: both ports are driven constant 0 and no counter flops are inferred.

Test Plan:
- Reset for 2 cycles, then idle 3 cycles → during reset PC_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1; afterwards PC_Write=1, IF_ID_Write=1, others 0.
- Stall_Req=1, Stall_Len=2 for one cycle → PC_Write=0 and ID_EX_Bubble=1 for exactly 2 cycles, Busy=1 on the 2nd cycle only, then back to RUN outputs.
- Stall_Len=3 with MAX_STALL=2 → clamped to 2 frozen cycles. Stall_Len=0 → 1 frozen cycle, Busy stays 0.
- Stall_Req=1 and Branch_Taken=1 in the same cycle, Stall_Len=1; Branch_Taken held next cycle → cycle 1 stall with no flush; cycle 2 IF_ID_Flush=1, PC_Write=1.
- Halt_Req=1 while Stall_Req=1 → HALT entered; outputs PC_Write=0, IF_ID_Flush=1 held for 10 cycles; Reset pulse returns to RUN.
- With STALL_PERF_EN: 2 stalls of length 2 plus 3 taken branches → Stall_Count=4, Flush_Count=3. Without the macro, both read 0.
